// File: rtl/mgmt_bank_pkg.sv
// mgmt_bank_pkg: register map offsets and read FSM state type for the management status/irq bank
package mgmt_bank_pkg;
  localparam logic [9:0] OFF_IRQ_STAT  = 10'h000;
  localparam logic [9:0] OFF_IRQ_MASK  = 10'h004;
  localparam logic [9:0] OFF_IRQ_FORCE = 10'h008;
  localparam logic [9:0] OFF_ERR_STAT  = 10'h00C;
  localparam logic [9:0] OFF_CHAN_BASE = 10'h200;
  localparam int         CHAN_STRIDE   = 8;
  typedef enum logic {RD_IDLE, RD_WAIT} rdstate_t;
endpackage

// File: rtl/mgmt_irq_ctrl.sv
// mgmt_irq_ctrl: edge-latched irq status with mask, W1C clear, software force and registered irq
module mgmt_irq_ctrl
  import mgmt_bank_pkg::*;
#(
  parameter int NUM_IRQ = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic               wr_en,
  input  logic [9:0]         wr_off,
  input  logic [7:0]         wr_data,
  output logic [31:0]        stat,
  output logic [31:0]        mask,
  output logic               irq
);
  localparam logic [31:0] IMASK = 32'hFFFF_FFFF >> (32 - NUM_IRQ);
  logic [NUM_IRQ-1:0] src_q, src_d;
  logic [31:0] stat_q, stat_d, mask_q, mask_d, wv, wm;
  logic irq_q, irq_d;
  always_comb begin
    wv     = 32'(wr_data) << {wr_off[1:0], 3'b0};
    wm     = 32'hFF << {wr_off[1:0], 3'b0};
    src_d  = irq_src;
    stat_d = ((stat_q & ~(wr_en && wr_off[9:2] == OFF_IRQ_STAT[9:2] ? wv : 32'h0))
             | 32'(irq_src & ~src_q)
             | (wr_en && wr_off[9:2] == OFF_IRQ_FORCE[9:2] ? wv : 32'h0)) & IMASK;
    mask_d = wr_en && wr_off[9:2] == OFF_IRQ_MASK[9:2] ? ((mask_q & ~wm) | wv) & IMASK : mask_q;
    irq_d  = |(stat_q & mask_q);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src_q  <= '0;
      stat_q <= '0;
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      src_q  <= src_d;
      stat_q <= stat_d;
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end
  assign stat = stat_q;
  assign mask = mask_q;
  assign irq  = irq_q;
endmodule

// File: rtl/mgmt_status_irq_bank.sv
// mgmt_status_irq_bank: byte-wide mgmt register bank with coherent channel snapshots and irq controller (optional read timeout: MGMT_BANK_READ_TIMEOUT_EN)
module mgmt_status_irq_bank
  import mgmt_bank_pkg::*;
#(
  parameter int          NUM_CHAN       = 8,
  parameter int          REG_BYTES      = 4,
  parameter int          NUM_IRQ        = 16,
  parameter logic [15:0] BASE_ADDR      = 16'h0100,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            rd_en,
  input  logic [15:0]                     rd_addr,
  output logic                            rd_valid,
  output logic [7:0]                      rd_data,
  output logic                            rd_hit,
  input  logic                            wr_en,
  input  logic [15:0]                     wr_addr,
  input  logic [7:0]                      wr_data,
  input  logic [NUM_CHAN-1:0]             chan_valid,
  input  logic [NUM_CHAN*REG_BYTES*8-1:0] chan_value,
  input  logic [NUM_IRQ-1:0]              irq_src,
  output logic                            irq
);
  localparam int W  = REG_BYTES * 8;
  localparam int SW = NUM_CHAN * W;
  rdstate_t state_q, state_d;
  logic [9:0] addr_q, addr_d;
  logic [7:0] rdata_q, rdata_d, rd_mux;
  logic [SW-1:0] shadow_q, shadow_d, shad_sh, csh;
  logic [15:0] roff, woff;
  logic [31:0] stat, mask, stat_sh, mask_sh;
  logic [NUM_CHAN-1:0] vsh;
  logic rd_in, wr_in, chan_ok, is_b0, stall, tmo, err_q, irq_core;
  int rc, rb, wc;
  mgmt_irq_ctrl #(.NUM_IRQ(NUM_IRQ)) u_irq (
    .clk     (clk),
    .rst_n   (rst_n),
    .irq_src (irq_src),
    .wr_en   (wr_in),
    .wr_off  (woff[9:0]),
    .wr_data (wr_data),
    .stat    (stat),
    .mask    (mask),
    .irq     (irq_core)
  );
  always_comb begin
    roff    = rd_addr - BASE_ADDR;
    woff    = wr_addr - BASE_ADDR;
    rd_in   = rd_en && roff < 16'h0400;
    wr_in   = wr_en && woff < 16'h0400;
    rc      = int'(roff[8:3]);
    rb      = int'(roff[2:0]);
    chan_ok = roff[9:0] >= OFF_CHAN_BASE && rc < NUM_CHAN && rb < REG_BYTES;
    stat_sh = stat >> {roff[1:0], 3'b0};
    mask_sh = mask >> {roff[1:0], 3'b0};
    shad_sh = chan_ok ? shadow_q >> (rc * W + rb * 8) : '0;
    rd_mux  = roff[9:2] == OFF_IRQ_STAT[9:2] ? stat_sh[7:0] :
              roff[9:2] == OFF_IRQ_MASK[9:2] ? mask_sh[7:0] :
              roff[9:0] == OFF_ERR_STAT ? {7'b0, err_q} : shad_sh[7:0];
  end
  always_comb begin
    wc    = int'(addr_q[8:3]);
    is_b0 = addr_q >= OFF_CHAN_BASE && addr_q[2:0] == 3'd0 && wc < NUM_CHAN;
    vsh   = chan_valid >> wc;
    csh   = chan_value >> (wc * W);
    stall = state_q == RD_WAIT && is_b0 && !vsh[0];
  end
`ifdef MGMT_BANK_READ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_d;
  always_comb begin
    tmo   = stall && cnt_q == CW'(TIMEOUT_CYCLES);
    cnt_d = state_q == RD_WAIT ? cnt_q + CW'(1) : '0;
    err_d = tmo | (err_q & !(wr_in && woff[9:0] == OFF_ERR_STAT && wr_data[0]));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  assign tmo   = 1'b0;
  assign err_q = 1'b0;
`endif
  always_comb begin
    rd_hit   = state_q == RD_WAIT;
    rd_valid = rd_hit && (!stall || tmo);
    rd_data  = !rd_valid ? 8'h00 : tmo ? 8'hEE : is_b0 ? csh[7:0] : rdata_q;
    state_d  = rd_valid ? RD_IDLE : state_q == RD_IDLE && rd_in ? RD_WAIT : state_q;
    addr_d   = state_q == RD_IDLE && rd_in ? roff[9:0] : addr_q;
    rdata_d  = state_q == RD_IDLE && rd_in ? rd_mux : rdata_q;
    shadow_d = rd_valid && is_b0 && !tmo
             ? (shadow_q & ~(SW'({W{1'b1}}) << (wc * W))) | (SW'(csh[W-1:0]) << (wc * W))
             : shadow_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= RD_IDLE;
      addr_q   <= '0;
      rdata_q  <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rdata_q  <= rdata_d;
      shadow_q <= shadow_d;
    end
  end
  assign irq = irq_core | err_q;
endmodule
